// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared FSM state encoding, op codes and client indices for muldiv_sched.
package muldiv_pkg;
  typedef enum logic [2:0] {IDLE, CONV, ITER, FIX, DONE} state_t;
  localparam logic OP_MUL  = 1'b1;
  localparam logic OP_DIV  = 1'b0;
  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: per-cycle unsigned shift-add multiply / restoring divide datapath.
// MULDIV_EARLY_TERM_EN: a multiply finishes once the remaining multiplier bits are all zero.
module muldiv_iter_core import muldiv_pkg::*; #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           op_i,
  input  logic           step_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_o,
  output logic [2*N-1:0] acc_o,
  output logic [N-1:0]   quo_o
);
  localparam int CW = $clog2(N);
  logic [2*N-1:0] acc_q, acc_d, mc_q, mc_d;
  logic [N-1:0] mb_q, mb_d, rem_sh;
  logic [N:0] diff;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mul;
  assign mul = op_i == OP_MUL;
  // remainder < divisor <= 2^(N-1), so the shifted partial remainder always fits N bits
  assign rem_sh = {acc_q[N-2:0], mb_q[N-1]};
  assign diff = {1'b0, rem_sh} - {1'b0, mc_q[N-1:0]};
  always_comb begin
    acc_d = start_i ? '0 : !step_i ? acc_q : mul ? acc_q + (mb_q[0] ? mc_q : '0)
          : {{N{1'b0}}, diff[N] ? rem_sh : diff[N-1:0]};
    mc_d = start_i ? {{N{1'b0}}, mul ? a_i : b_i} : (step_i && mul) ? mc_q << 1 : mc_q;
    mb_d = start_i ? (mul ? b_i : a_i) : !step_i ? mb_q : mul ? mb_q >> 1 : {mb_q[N-2:0], !diff[N]};
    cnt_d = start_i ? '0 : step_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q <= '0;
      mc_q  <= '0;
      mb_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mb_q  <= mb_d;
      cnt_q <= cnt_d;
    end
`ifdef MULDIV_EARLY_TERM_EN
  assign done_o = cnt_q == CW'(N - 1) || (mul && mb_q[N-1:1] == '0);
`else
  assign done_o = cnt_q == CW'(N - 1);
`endif
  assign acc_o = acc_q;
  assign quo_o = mb_q;
endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: round-robin arbiter and FSM sequencing a shared iterative signed mul/div core.
// MULDIV_EARLY_TERM_EN (handled in muldiv_iter_core) shortens multiplies with small multipliers.
module muldiv_sched import muldiv_pkg::*; #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic         sel0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic         sel1,
  output logic         gnt1,
  output logic         busy,
  output logic         valid,
  output logic         error,
  output logic         owner,
  output logic [N-1:0] m,
  output logic [N-1:0] r
);
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};
  state_t state_q;
  logic fav_q, own_q, op_q, sa_q, sb_q, valid_q, err_q, owner_q, idle, ovf, done;
  logic [N-1:0] a_q, b_q, m_q, r_q, mag_a, mag_b, quo, qfix, rfix;
  logic [2*N-1:0] acc, pfix;
  // grants are gated by rst so they drop the moment reset asserts
  assign idle = state_q == IDLE && !rst;
  assign gnt0 = idle && req0 && (!req1 || fav_q == CLIENT0);
  assign gnt1 = idle && req1 && (!req0 || fav_q == CLIENT1);
  assign mag_a = a_q[N-1] ? -a_q : a_q;
  assign mag_b = b_q[N-1] ? -b_q : b_q;
  assign pfix = (sa_q ^ sb_q) ? -acc : acc;
  assign qfix = (sa_q ^ sb_q) ? -quo : quo;
  assign rfix = sa_q ? -acc[N-1:0] : acc[N-1:0];
  assign ovf = a_q == MIN && b_q == '1;
  muldiv_iter_core #(.N(N)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start_i(state_q == CONV),
    .op_i   (op_q),
    .step_i (state_q == ITER),
    .a_i    (mag_a),
    .b_i    (mag_b),
    .done_o (done),
    .acc_o  (acc),
    .quo_o  (quo)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      fav_q   <= CLIENT0;
      own_q   <= CLIENT0;
      op_q    <= OP_DIV;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      owner_q <= CLIENT0;
      m_q     <= '0;
      r_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (gnt0 || gnt1) begin
          state_q <= CONV;
          own_q   <= gnt1 ? CLIENT1 : CLIENT0;
          fav_q   <= gnt1 ? CLIENT0 : CLIENT1;
          a_q     <= gnt1 ? a1 : a0;
          b_q     <= gnt1 ? b1 : b0;
          op_q    <= gnt1 ? sel1 : sel0;
        end
        CONV: begin
          sa_q <= a_q[N-1];
          sb_q <= b_q[N-1];
          if (op_q == OP_DIV && b_q == '0) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            owner_q <= own_q;
            m_q     <= '0;
            r_q     <= '0;
          end else state_q <= ITER;
        end
        ITER: if (done) state_q <= FIX;
        FIX: begin
          state_q <= DONE;
          valid_q <= 1'b1;
          owner_q <= own_q;
          err_q   <= op_q == OP_DIV && ovf;
          m_q     <= op_q == OP_MUL ? pfix[2*N-1:N] : ovf ? MIN : qfix;
          r_q     <= op_q == OP_MUL ? pfix[N-1:0] : ovf ? '0 : rfix;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy  = state_q != IDLE;
  assign valid = valid_q;
  assign error = err_q;
  assign owner = owner_q;
  assign m     = m_q;
  assign r     = r_q;
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed vectors with literal expectations plus a per-cycle arithmetic model.
// Honours MULDIV_EARLY_TERM_EN for multiply latency.
module tb_muldiv_sched;
  localparam int N = 4;
`ifdef MULDIV_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0, sel0 = 0, sel1 = 0;
  logic [N-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic gnt0, gnt1, busy, valid, error, owner;
  logic [N-1:0] m, r;
  int vectors = 0, errs = 0, cyc = 0, gcyc = 0, due = 0, n, pl;
  logic pend = 0, fav = 0, eo = 0, ee = 0, eg0, eg1, pe;
  logic [N-1:0] em = 0, er = 0, pm, pr;

  muldiv_sched #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sel0(sel0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .sel1(sel1), .gnt1(gnt1),
    .busy(busy), .valid(valid), .error(error), .owner(owner), .m(m), .r(r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // signed arithmetic reference: result fields and gnt->valid latency
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sel,
                                output logic [N-1:0] om, output logic [N-1:0] orr,
                                output logic oe, output int lat);
    logic signed [N-1:0] sa = a;
    logic signed [N-1:0] sb = b;
    int x, y, p, mag;
    x = sa;
    y = sb;
    oe = 0;
    lat = N + 3;
    if (sel) begin
      p = x * y;
      {om, orr} = p[2*N-1:0];
      if (ET) begin
        mag = y < 0 ? -y : y;
        lat = 4;
        for (int i = 0; i <= N; i++) if (mag[i]) lat = 4 + i;
      end
    end else if (y == 0) begin
      om = 0; orr = 0; oe = 1; lat = 2;
    end else if (x == -(1 << (N - 1)) && y == -1) begin
      om = {1'b1, {(N-1){1'b0}}}; orr = 0; oe = 1;
    end else begin
      p = x / y;
      om = p[N-1:0];
      p = x % y;
      orr = p[N-1:0];
    end
  endfunction

  always @(negedge clk) begin
    int lat;
    if (rst) begin
      pend = 0;
      fav = 0;
      chk("reset_outputs", {gnt0, gnt1, busy, valid, error, owner, m, r}, 0);
    end else begin
      eg0 = !pend && req0 && (!req1 || !fav);
      eg1 = !pend && req1 && (!req0 || fav);
      chk("grant_pattern", {gnt0, gnt1}, {eg0, eg1});
      chk("busy", busy, pend && cyc > gcyc);
      chk("valid", valid, pend && cyc == due);
      if (pend && cyc == due) begin
        chk("model_result", {error, owner, m, r}, {ee, eo, em, er});
        pend = 0;
      end
      if (eg0 || eg1) begin
        if (eg1) model(a1, b1, sel1, em, er, ee, lat);
        else model(a0, b0, sel0, em, er, ee, lat);
        pend = 1; gcyc = cyc; due = cyc + lat; eo = eg1; fav = eg0;
      end
    end
  end

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!valid && cnt < 40);
  endtask

  task automatic run(input logic c, input logic [N-1:0] a, input logic [N-1:0] b, input logic sel,
                     input logic [N-1:0] xm, input logic [N-1:0] xr, input logic xe, input int xlat);
    int k;
    @(posedge clk); #1;
    if (c) begin req1 = 1; a1 = a; b1 = b; sel1 = sel; end
    else begin req0 = 1; a0 = a; b0 = b; sel0 = sel; end
    k = 0;
    do begin @(negedge clk); k++; end while (!(c ? gnt1 : gnt0) && k < 20);
    chk("grant", c ? gnt1 : gnt0, 1);
    @(posedge clk); #1;
    if (c) req1 = 0; else req0 = 0;
    wait_valid(k);
    chk("latency", k, xlat);
    chk("result", {error, owner, m, r}, {xe, c, xm, xr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model(4'd5, 4'd2, 1'b1, pm, pr, pe, pl);
    chk("pin_mul", {pe, pm, pr}, {1'b0, 8'h0A});
    model(4'd7, 4'hE, 1'b0, pm, pr, pe, pl);
    chk("pin_div", {pe, pm, pr}, {1'b0, 4'hD, 4'h1});
    model(4'h8, 4'hF, 1'b0, pm, pr, pe, pl);
    chk("pin_ovf", {pe, pm, pr}, {1'b1, 4'h8, 4'h0});
    model(4'd3, 4'd0, 1'b0, pm, pr, pe, pl);
    chk("pin_dz_lat", pl, 2);
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    run(1'b0, 4'd5, 4'd2, 1'b1, 4'h0, 4'hA, 1'b0, ET ? 5 : 7);
    run(1'b1, 4'hA, 4'd2, 1'b0, 4'hD, 4'h0, 1'b0, 7);
    run(1'b1, 4'd7, 4'hE, 1'b0, 4'hD, 4'h1, 1'b0, 7);
    run(1'b0, 4'd3, 4'd0, 1'b0, 4'h0, 4'h0, 1'b1, 2);
    run(1'b0, 4'h8, 4'hF, 1'b0, 4'h8, 4'h0, 1'b1, 7);
    run(1'b1, 4'h8, 4'h8, 1'b1, 4'h4, 4'h0, 1'b0, 7);
    run(1'b0, 4'd5, 4'd1, 1'b1, 4'h0, 4'h5, 1'b0, ET ? 4 : 7);
    // abort a client-0 multiply in ITER; the pointer must come back favouring client 0
    @(posedge clk); #1; req0 = 1; a0 = 4'd5; b0 = 4'd3; sel0 = 1;
    @(negedge clk); chk("abort_gnt", gnt0, 1);
    @(posedge clk); #1; req0 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1; chk("abort_busy_before", busy, 1);
    a0 = 4'd2; b0 = 4'd3; sel0 = 1; a1 = 4'h9; b1 = 4'd2; sel1 = 0;
    req0 = 1; req1 = 1; rst = 1;
    #1 chk("abort_drop", {busy, valid, gnt0, gnt1}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); chk("rr_first", {gnt0, gnt1}, 2'b10);
    @(posedge clk); #1; req0 = 0;
    wait_valid(n); chk("rr_owner0", {valid, owner}, 2'b10);
    @(negedge clk); chk("rr_second", {gnt0, gnt1}, 2'b01);
    @(posedge clk); #1; req0 = 1; a0 = 4'h8; b0 = 4'h8; a1 = 4'd7; b1 = 4'hE;
    wait_valid(n); chk("rr_owner1", {valid, owner}, 2'b11);
    @(negedge clk); chk("rr_third", {gnt0, gnt1}, 2'b10);
    @(posedge clk); #1; req0 = 0;
    wait_valid(n); chk("rr_owner0b", {valid, owner}, 2'b10);
    @(negedge clk); chk("rr_fourth", {gnt0, gnt1}, 2'b01);
    @(posedge clk); #1; req1 = 0;
    wait_valid(n); chk("rr_owner1b", {valid, owner}, 2'b11);
    run(1'b1, 4'd3, 4'hD, 1'b1, 4'hF, 4'h7, 1'b0, ET ? 5 : 7);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
